button_debounce: RTL and testbench

//  Conditions one raw, bouncy, active-low push-button input into a clean, glitch-free level.

---
 rtl/button_pkg.sv | 15 +
 rtl/button_debounce_if.sv | 31 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 112 +++++++++++
 tb/tb_button_debounce.sv | 135 +++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  // Defaults for a 27 MHz system clock: 10 ms debounce, 1 s long press.
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 270_000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 27_000_000;

endpackage

// File: rtl/button_debounce_if.sv
// Raw button input and the conditioned level/event outputs of the debouncer.
// The slave side is the debouncer; the master side is whoever drives the pad
// and consumes the events.
interface button_debounce_if;

  logic button_raw_n;
  logic btn_n_o;
  logic press_o;
  logic release_o;
  logic long_press_o;
  logic long_active_o;

  modport master (
    output button_raw_n,
    input  btn_n_o,
    input  press_o,
    input  release_o,
    input  long_press_o,
    input  long_active_o
  );

  modport slave (
    input  button_raw_n,
    output btn_n_o,
    output press_o,
    output release_o,
    output long_press_o,
    output long_active_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the pad level through two flops to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces one active-low push button and derives press, release and
// long-press event pulses from the accepted level.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input logic               clk,
  input logic               rst_n,
  button_debounce_if.slave  btn_if
);

  // Both counters share one width, sized for the longer hold count.
  localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  btn_state_t       state;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] hcnt;
  logic             btn_s;
  logic             btn_n_q;
  logic             press_q;
  logic             release_q;
  logic             long_press_q;
  logic             long_active_q;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_if.button_raw_n),
    .q     (btn_s)
  );

  // Debounce FSM: an edge is accepted only after the synchronised level holds
  // for DEBOUNCE_CYCLES; any bounce sends it back and restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      dcnt          <= '0;
      hcnt          <= '0;
      btn_n_q       <= 1'b1;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_press_q  <= 1'b0;
      long_active_q <= 1'b0;
    end else begin
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (!btn_s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (btn_s) begin
            state <= RELEASED;
            dcnt  <= '0;
          end else if (dcnt == DEB_LAST) begin
            state   <= PRESSED;
            btn_n_q <= 1'b0;
            press_q <= 1'b1;
            hcnt    <= '0;
          end else begin
            dcnt <= dcnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (btn_s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else begin
            if (hcnt != HOLD_LAST) begin
              hcnt <= hcnt + CNT_ONE;
            end
            if ((hcnt == HOLD_LAST) && !long_active_q) begin
              long_press_q  <= 1'b1;
              long_active_q <= 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (!btn_s) begin
            state <= PRESSED;
          end else if (dcnt == DEB_LAST) begin
            state         <= RELEASED;
            btn_n_q       <= 1'b1;
            release_q     <= 1'b1;
            long_active_q <= 1'b0;
          end else begin
            dcnt <= dcnt + CNT_ONE;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

  assign btn_if.btn_n_o       = btn_n_q;
  assign btn_if.press_o       = press_q;
  assign btn_if.release_o     = release_q;
  assign btn_if.long_press_o  = long_press_q;
  assign btn_if.long_active_o = long_active_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so "edge k" below is the k-th rising edge after the input changed.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  button_debounce_if bif ();

  button_debounce #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_if (bif.slave)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic raw);
    bif.button_raw_n = raw;
  endtask

  task automatic check_output(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic e_btn, input logic e_press,
                           input logic e_rel, input logic e_lp, input logic e_la);
    check_output({tag, ".btn_n_o"},       bif.btn_n_o,       e_btn);
    check_output({tag, ".press_o"},       bif.press_o,       e_press);
    check_output({tag, ".release_o"},     bif.release_o,     e_rel);
    check_output({tag, ".long_press_o"},  bif.long_press_o,  e_lp);
    check_output({tag, ".long_active_o"}, bif.long_active_o, e_la);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply_stimulus(1'b1);

    // 1. Reset held while the raw input toggles.
    $display("[TB] reset with toggling input");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(~bif.button_raw_n);
      step();
      check_all($sformatf("reset[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_all("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. Clean press then clean release.
    $display("[TB] clean press and release");
    apply_stimulus(1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_all($sformatf("press[%0d]", k), (k >= 7) ? 1'b0 : 1'b1, k == 7, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      check_all($sformatf("release[%0d]", k), (k >= 7) ? 1'b1 : 1'b0, 1'b0, k == 7, 1'b0, 1'b0);
    end

    // 3. Short bounces never reach the debounce threshold.
    $display("[TB] bounce rejection");
    for (int k = 1; k <= 16; k++) begin
      apply_stimulus(!((k >= 1 && k <= 3) || (k >= 5 && k <= 7)));
      step();
      check_all($sformatf("bounce[%0d]", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 4+5. Bounce then steady low; long press 20 edges after press_o; one pulse over a long hold.
    $display("[TB] bounce then settle, long press");
    for (int k = 1; k <= 70; k++) begin
      apply_stimulus(k == 3);
      step();
      check_all($sformatf("hold[%0d]", k), (k >= 10) ? 1'b0 : 1'b1, k == 10, 1'b0,
                k == 30, k >= 30);
    end
    apply_stimulus(1'b1);
    for (int k = 1; k <= 9; k++) begin
      step();
      check_all($sformatf("long_rel[%0d]", k), (k >= 7) ? 1'b1 : 1'b0, 1'b0, k == 7,
                1'b0, k < 7);
    end

    // 6. Reset asserted while held; press re-detected after reset release.
    $display("[TB] reset mid-hold");
    apply_stimulus(1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check_all($sformatf("pre_rst[%0d]", k), (k >= 7) ? 1'b0 : 1'b1, k == 7, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_all($sformatf("in_rst[%0d]", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_all($sformatf("post_rst[%0d]", k), (k >= 7) ? 1'b0 : 1'b1, k == 7, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
